// File: rtl/control_sequencer.sv
// control_sequencer
//   Microsequencer for the basic processor. Fetches, decodes and executes one
//   instruction at a time and drives the datapath/memory strobes on the shared
//   sysbus. Memory accesses handshake on mem_ready, and a wait-state counter
//   moves the machine to a sticky FAULT state when memory stalls too long.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high; returns to IDLE, clears wait counter
//   start      in   leave IDLE and begin fetching (ignored elsewhere)
//   op         in   opcode field from IR, valid from DECODE onward
//   z_flag     in   ACC==0 flag from the ALU
//   mem_ready  in   memory completed the current access this cycle
//   PC_bus .. R_NW  out  datapath / memory strobes
//   busy       out  FSM is neither in IDLE nor in FAULT
//   instr_done out  last cycle of each instruction
//   fault      out  memory timeout occurred; held until reset

module control_sequencer #(
  parameter int unsigned OP_W     = 3,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            IR_bus,
  output logic            load_IR,
  output logic            load_MAR,
  output logic            MDR_bus,
  output logic            load_MDR,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            CS,
  output logic            R_NW,
  output logic            busy,
  output logic            instr_done,
  output logic            fault
);

  // Counter only has to reach WAIT_MAX-1.
  localparam int unsigned CNT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  typedef enum logic [3:0] {
    S_IDLE,
    S_F_ADDR,
    S_F_READ,
    S_F_IR,
    S_DECODE,
    S_X_READ,
    S_X_WB,
    S_X_STA,
    S_X_STW,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             stall_timeout;

  assign stall_timeout = !mem_ready && (wait_q == WAIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state. The wait counter is zeroed on every transition into a memory
  // state, so it always counts stalls of the current access only.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_F_ADDR;
      S_F_ADDR: begin
        state_d = S_F_READ;
        wait_d  = '0;
      end
      S_F_READ: begin
        if (mem_ready)          state_d = S_F_IR;
        else if (stall_timeout) state_d = S_FAULT;
        else                    wait_d  = wait_q + 1'b1;
      end
      S_F_IR:   state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_ADD, OP_SUB: begin
            state_d = S_X_READ;
            wait_d  = '0;
          end
          OP_STORE: state_d = S_X_STA;
          OP_HALT:  state_d = S_IDLE;
          default:  state_d = S_F_ADDR;
        endcase
      end
      S_X_READ: begin
        if (mem_ready)          state_d = S_X_WB;
        else if (stall_timeout) state_d = S_FAULT;
        else                    wait_d  = wait_q + 1'b1;
      end
      S_X_WB:   state_d = S_F_ADDR;
      S_X_STA: begin
        state_d = S_X_STW;
        wait_d  = '0;
      end
      S_X_STW: begin
        if (mem_ready)          state_d = S_F_ADDR;
        else if (stall_timeout) state_d = S_FAULT;
        else                    wait_d  = wait_q + 1'b1;
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the current state together with same-cycle
  // op/z_flag/mem_ready, so the datapath latches on the cycle memory answers.
  always_comb begin
    PC_bus     = 1'b0;
    load_PC    = 1'b0;
    INC_PC     = 1'b0;
    IR_bus     = 1'b0;
    load_IR    = 1'b0;
    load_MAR   = 1'b0;
    MDR_bus    = 1'b0;
    load_MDR   = 1'b0;
    ACC_bus    = 1'b0;
    load_ACC   = 1'b0;
    ALU_add    = 1'b0;
    ALU_sub    = 1'b0;
    CS         = 1'b0;
    R_NW       = 1'b0;
    instr_done = 1'b0;
    busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
    fault      = (state_q == S_FAULT);
    unique case (state_q)
      S_F_ADDR: begin
        PC_bus   = 1'b1;
        load_MAR = 1'b1;
        load_PC  = 1'b1;
        INC_PC   = 1'b1;
      end
      S_F_READ, S_X_READ: begin
        CS       = 1'b1;
        R_NW     = 1'b1;
        load_MDR = mem_ready;
      end
      S_F_IR: begin
        MDR_bus = 1'b1;
        load_IR = 1'b1;
      end
      S_DECODE: begin
        IR_bus = 1'b1;
        case (op)
          OP_LOAD, OP_ADD, OP_SUB, OP_STORE: load_MAR = 1'b1;
          OP_JMP: begin
            load_PC    = 1'b1;
            instr_done = 1'b1;
          end
          OP_BNE: begin
            load_PC    = !z_flag;
            instr_done = 1'b1;
          end
          OP_NOP, OP_HALT: instr_done = 1'b1;
          default: ;
        endcase
      end
      S_X_WB: begin
        MDR_bus    = 1'b1;
        load_ACC   = 1'b1;
        ALU_add    = (op == OP_ADD);
        ALU_sub    = (op == OP_SUB);
        instr_done = 1'b1;
      end
      S_X_STA: begin
        ACC_bus  = 1'b1;
        load_MDR = 1'b1;
      end
      S_X_STW: begin
        MDR_bus    = 1'b1;
        CS         = 1'b1;
        instr_done = mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: per-cycle vectors of inputs and the
// expected strobe word, plus hand sequences for reset, timeout and stall cases.

module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic       z_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic PC_bus, load_PC, INC_PC, IR_bus, load_IR, load_MAR, MDR_bus, load_MDR;
  logic ACC_bus, load_ACC, ALU_add, ALU_sub, CS, R_NW, busy, instr_done, fault;

  control_sequencer #(.OP_W(3), .WAIT_MAX(4)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .z_flag(z_flag),
    .mem_ready(mem_ready),
    .PC_bus(PC_bus), .load_PC(load_PC), .INC_PC(INC_PC), .IR_bus(IR_bus),
    .load_IR(load_IR), .load_MAR(load_MAR), .MDR_bus(MDR_bus), .load_MDR(load_MDR),
    .ACC_bus(ACC_bus), .load_ACC(load_ACC), .ALU_add(ALU_add), .ALU_sub(ALU_sub),
    .CS(CS), .R_NW(R_NW), .busy(busy), .instr_done(instr_done), .fault(fault)
  );

  always #5 clock = ~clock;

  localparam logic [16:0] M_PCB  = 17'h10000, M_LPC  = 17'h08000, M_INC  = 17'h04000;
  localparam logic [16:0] M_IRB  = 17'h02000, M_LIR  = 17'h01000, M_LMAR = 17'h00800;
  localparam logic [16:0] M_MDRB = 17'h00400, M_LMDR = 17'h00200, M_ACCB = 17'h00100;
  localparam logic [16:0] M_LACC = 17'h00080, M_ADD  = 17'h00040, M_SUB  = 17'h00020;
  localparam logic [16:0] M_CS   = 17'h00010, M_RNW  = 17'h00008, M_BSY  = 17'h00004;
  localparam logic [16:0] M_DONE = 17'h00002, M_FLT  = 17'h00001;

  localparam logic [16:0] E_IDLE = 17'h0;
  localparam logic [16:0] E_FA   = M_PCB | M_LPC | M_INC | M_LMAR | M_BSY;
  localparam logic [16:0] E_RDOK = M_CS | M_RNW | M_LMDR | M_BSY;
  localparam logic [16:0] E_RDW  = M_CS | M_RNW | M_BSY;
  localparam logic [16:0] E_FI   = M_MDRB | M_LIR | M_BSY;
  localparam logic [16:0] E_DMEM = M_IRB | M_LMAR | M_BSY;
  localparam logic [16:0] E_DBR  = M_IRB | M_LPC | M_DONE | M_BSY;
  localparam logic [16:0] E_DNB  = M_IRB | M_DONE | M_BSY;
  localparam logic [16:0] E_WB   = M_MDRB | M_LACC | M_DONE | M_BSY;

  typedef struct {
    logic        rst;
    logic        st;
    logic [2:0]  opc;
    logic        z;
    logic        mr;
    logic [16:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [16:0] outs();
    return {PC_bus, load_PC, INC_PC, IR_bus, load_IR, load_MAR, MDR_bus, load_MDR,
            ACC_bus, load_ACC, ALU_add, ALU_sub, CS, R_NW, busy, instr_done, fault};
  endfunction

  task automatic add(input logic r, input logic s, input logic [2:0] o, input logic z,
                     input logic m, input logic [16:0] e, input string t);
    vec_t v;
    v.rst = r; v.st = s; v.opc = o; v.z = z; v.mr = m; v.exp = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [2:0] o);
    add(0, 0, o, 0, 1, E_FA,   "f_addr");
    add(0, 1, o, 0, 1, E_RDOK, "f_read");
    add(0, 0, o, 0, 1, E_FI,   "f_ir");
  endtask

  // Drive one cycle of inputs after the falling edge, check just after.
  task automatic step(input logic r, input logic s, input logic [2:0] o, input logic z,
                      input logic m, input logic [16:0] e, input string t);
    logic [16:0] got;
    @(negedge clock);
    reset = r; start = s; op = o; z_flag = z; mem_ready = m;
    #1;
    got = outs();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %05h expected %05h", t, $time, got, e);
    end
  endtask

  initial begin
    // LOAD, zero-wait memory: six cycles, back in F_ADDR on the seventh
    add(0, 1, 3'd0, 0, 1, E_IDLE, "idle_start");
    add_fetch(3'd0);
    add(0, 0, 3'd0, 0, 1, E_DMEM, "load_decode");
    add(0, 0, 3'd0, 0, 1, E_RDOK, "load_xread");
    add(0, 0, 3'd0, 0, 1, E_WB,   "load_wb");
    // ADD with three wait states in X_READ
    add_fetch(3'd2);
    add(0, 0, 3'd2, 0, 1, E_DMEM, "add_decode");
    add(0, 0, 3'd2, 0, 0, E_RDW,  "add_wait1");
    add(0, 0, 3'd2, 0, 0, E_RDW,  "add_wait2");
    add(0, 0, 3'd2, 0, 0, E_RDW,  "add_wait3");
    add(0, 0, 3'd2, 0, 1, E_RDOK, "add_xread_ok");
    add(0, 0, 3'd2, 0, 1, E_WB | M_ADD, "add_wb");
    // BNE taken and not taken
    add_fetch(3'd4);
    add(0, 0, 3'd4, 0, 1, E_DBR, "bne_taken");
    add_fetch(3'd4);
    add(0, 0, 3'd4, 1, 1, E_DNB, "bne_not_taken");
    // SUB
    add_fetch(3'd3);
    add(0, 0, 3'd3, 0, 1, E_DMEM, "sub_decode");
    add(0, 0, 3'd3, 0, 1, E_RDOK, "sub_xread");
    add(0, 0, 3'd3, 0, 1, E_WB | M_SUB, "sub_wb");
    // STORE with one wait state in X_STW
    add_fetch(3'd1);
    add(0, 0, 3'd1, 0, 1, E_DMEM, "store_decode");
    add(0, 0, 3'd1, 0, 0, M_ACCB | M_LMDR | M_BSY, "store_sta");
    add(0, 0, 3'd1, 0, 0, M_MDRB | M_CS | M_BSY, "store_stw_wait");
    add(0, 0, 3'd1, 0, 1, M_MDRB | M_CS | M_DONE | M_BSY, "store_stw_ok");
    // JMP, NOP, HALT
    add_fetch(3'd5);
    add(0, 0, 3'd5, 1, 1, E_DBR, "jmp_decode");
    add_fetch(3'd6);
    add(0, 0, 3'd6, 0, 1, E_DNB, "nop_decode");
    add_fetch(3'd7);
    add(0, 0, 3'd7, 0, 1, E_DNB, "halt_decode");
    add(0, 0, 3'd7, 0, 1, E_IDLE, "halt_idle");
    add(0, 1, 3'd0, 0, 1, E_IDLE, "idle_restart");

    // Reset for two cycles, then the machine must sit in IDLE
    reset = 1'b1;
    repeat (2) @(posedge clock);
    step(0, 0, 3'd0, 0, 0, E_IDLE, "reset_idle");

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].st, vecs[i].opc, vecs[i].z, vecs[i].mr,
           vecs[i].exp, vecs[i].tag);

    // Relaunched by idle_restart: reset held two cycles mid-X_READ
    step(0, 0, 3'd0, 0, 1, E_FA,   "rst_f_addr");
    step(0, 0, 3'd0, 0, 1, E_RDOK, "rst_f_read");
    step(0, 0, 3'd0, 0, 1, E_FI,   "rst_f_ir");
    step(0, 0, 3'd0, 0, 1, E_DMEM, "rst_decode");
    step(0, 0, 3'd0, 0, 0, E_RDW,  "rst_xread");
    step(1, 1, 3'd0, 0, 0, E_RDW,  "rst_cycle1");
    step(1, 1, 3'd0, 0, 1, E_IDLE, "rst_cycle2");
    step(0, 0, 3'd0, 0, 1, E_IDLE, "rst_after");

    // Timeout: mem_ready stuck low in F_READ with WAIT_MAX=4
    step(0, 1, 3'd0, 0, 0, E_IDLE, "to_start");
    step(0, 0, 3'd0, 0, 0, E_FA,   "to_f_addr");
    for (int unsigned k = 0; k < 4; k++)
      step(0, 0, 3'd0, 0, 0, E_RDW, "to_f_read_wait");
    step(0, 1, 3'd0, 0, 1, M_FLT, "to_fault1");
    step(0, 1, 3'd0, 0, 1, M_FLT, "to_fault2");
    step(0, 1, 3'd0, 0, 0, M_FLT, "to_fault3");
    step(1, 0, 3'd0, 0, 0, M_FLT, "to_fault_rst");
    step(0, 0, 3'd0, 0, 0, E_IDLE, "to_cleared");

    // mem_ready on the last allowed wait cycle wins over the timeout,
    // and the counter restarts for the execute read
    step(0, 1, 3'd2, 0, 0, E_IDLE, "bd_start");
    step(0, 0, 3'd2, 0, 0, E_FA,   "bd_f_addr");
    for (int unsigned k = 0; k < 3; k++)
      step(0, 0, 3'd2, 0, 0, E_RDW, "bd_f_wait");
    step(0, 0, 3'd2, 0, 1, E_RDOK, "bd_f_last_ok");
    step(0, 0, 3'd2, 0, 1, E_FI,   "bd_f_ir");
    step(0, 0, 3'd2, 0, 1, E_DMEM, "bd_decode");
    for (int unsigned k = 0; k < 3; k++)
      step(0, 0, 3'd2, 0, 0, E_RDW, "bd_x_wait");
    step(0, 0, 3'd2, 0, 1, E_RDOK, "bd_x_last_ok");
    step(0, 0, 3'd2, 0, 1, E_WB | M_ADD, "bd_wb");
    step(0, 0, 3'd2, 0, 1, E_FA,   "bd_next_fetch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
